// File: rtl/cap_sensor_scan_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : cap_sensor_scan_scheduler_if
// Purpose  : Processor/pin-side bundle for the capacitive scan scheduler.
//            The master drives enable, raw pads, threshold writes and read
//            select. The slave returns the drive line, touch flags, counts
//            and status.
// Revision : 1.0 - initial release
// ============================================================================
interface cap_sensor_scan_scheduler_if #(
  parameter int NUM_SENSORS = 9,
  parameter int CNT_W       = 16
);
  logic                   enable;
  logic [NUM_SENSORS-1:0] capacitive_sensors_in;
  logic                   thresh_we;
  logic [CNT_W-1:0]       thresh_in;
  logic [3:0]             rd_sel;
  logic                   capacitive_sensors_out;
  logic [NUM_SENSORS-1:0] touched;
  logic [CNT_W-1:0]       rd_count;
  logic                   scan_done;
  logic                   busy;

  modport master (
    output enable, capacitive_sensors_in, thresh_we, thresh_in, rd_sel,
    input  capacitive_sensors_out, touched, rd_count, scan_done, busy
  );

  modport slave (
    input  enable, capacitive_sensors_in, thresh_we, thresh_in, rd_sel,
    output capacitive_sensors_out, touched, rd_count, scan_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/cap_sensor_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cap_sensor_scan_scheduler
// Purpose  : Shares one capacitive drive line across the mole pads. Each scan
//            charges all pads and releases them. It then times every pad's
//            discharge in parallel and publishes saturated counts and touch
//            flags.
// Options  : DEBOUNCE_EN - a touch flag changes only when two consecutive
//            scans agree.
// Revision : 1.0 - initial release
// ============================================================================
module cap_sensor_scan_scheduler #(
  parameter int NUM_SENSORS   = 9,
  parameter int CNT_W         = 16,
  parameter int CHARGE_CYCLES = 500,
  parameter int TIMEOUT       = 4095,
  parameter int THRESH_RST    = 200
) (
  input  logic                        clock,
  input  logic                        reset,
  cap_sensor_scan_scheduler_if.slave  bus
);

  localparam int               PH_W         = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;
  localparam logic [PH_W-1:0]  PH_LAST      = PH_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] THRESH_RST_C = CNT_W'(THRESH_RST);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHARGE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]       meas_q, meas_d;
  logic [CNT_W-1:0]       cnt_q [NUM_SENSORS];
  logic [CNT_W-1:0]       cnt_d [NUM_SENSORS];
  logic [CNT_W-1:0]       committed_q [NUM_SENSORS];
  logic [CNT_W-1:0]       committed_d [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] touched_q, touched_d;
  logic [CNT_W-1:0]       thresh_q, thresh_d;
  logic [NUM_SENSORS-1:0] sync1_q, sync1_d;
  logic [NUM_SENSORS-1:0] sync2_q, sync2_d;
  logic                   drive_q, drive_d;
  logic                   busy_q, busy_d;
  logic                   scan_done_q, scan_done_d;
  logic [NUM_SENSORS-1:0] raw_cmp;
  logic [CNT_W-1:0]       rd_count;
`ifdef DEBOUNCE_EN
  logic [NUM_SENSORS-1:0] prev_raw_q, prev_raw_d;
`endif

  // Next-state, counters, commit and status decode for the scan sequencer.
  always_comb begin
    state_d     = state_q;
    phase_d     = '0;
    meas_d      = meas_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    touched_d   = touched_q;
    thresh_d    = bus.thresh_we ? bus.thresh_in : thresh_q;
    sync1_d     = bus.capacitive_sensors_in;
    sync2_d     = sync1_q;
`ifdef DEBOUNCE_EN
    prev_raw_d  = prev_raw_q;
`endif
    for (int i = 0; i < NUM_SENSORS; i++) begin
      raw_cmp[i] = (cnt_q[i] >= thresh_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = ST_CHARGE;
        end
      end
      ST_CHARGE: begin
        meas_d = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
          cnt_d[i] = '0;
        end
        if (phase_q == PH_LAST) begin
          state_d = ST_MEASURE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        meas_d = meas_q + 1'b1;
        for (int i = 0; i < NUM_SENSORS; i++) begin
          if (sync2_q[i] && (cnt_q[i] < TIMEOUT_C)) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        // Stop once every pad has discharged or the window is exhausted.
        if ((sync2_q == '0) || (meas_d == TIMEOUT_C)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        committed_d = cnt_q;
`ifdef DEBOUNCE_EN
        // Only a result that repeats the previous scan may move the flag.
        for (int i = 0; i < NUM_SENSORS; i++) begin
          if (raw_cmp[i] == prev_raw_q[i]) begin
            touched_d[i] = raw_cmp[i];
          end
        end
        prev_raw_d = raw_cmp;
`else
        touched_d = raw_cmp;
`endif
        state_d = bus.enable ? ST_CHARGE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered and aligned with the state they describe.
    drive_d     = (state_d == ST_CHARGE);
    busy_d      = (state_d != ST_IDLE);
    scan_done_d = (state_d == ST_COMMIT);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      meas_q      <= '0;
      cnt_q       <= '{default: '0};
      committed_q <= '{default: '0};
      touched_q   <= '0;
      thresh_q    <= THRESH_RST_C;
      sync1_q     <= '0;
      sync2_q     <= '0;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
`ifdef DEBOUNCE_EN
      prev_raw_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      meas_q      <= meas_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      touched_q   <= touched_d;
      thresh_q    <= thresh_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      drive_q     <= drive_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
`ifdef DEBOUNCE_EN
      prev_raw_q  <= prev_raw_d;
`endif
    end
  end

  // Read port: committed count of the selected pad, zero when out of range.
  always_comb begin
    rd_count = '0;
    if (int'(bus.rd_sel) < NUM_SENSORS) begin
      rd_count = committed_q[bus.rd_sel];
    end
  end

  assign bus.capacitive_sensors_out = drive_q;
  assign bus.touched                = touched_q;
  assign bus.rd_count               = rd_count;
  assign bus.scan_done              = scan_done_q;
  assign bus.busy                   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cap_sensor_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cap_sensor_scan_scheduler
// Purpose  : Self-checking bench for cap_sensor_scan_scheduler. It emulates
//            pads that stay high for a chosen number of cycles after release.
//            Expected results come from the scan rules: count = high time plus
//            2 sync cycles, saturated; flag = count >= threshold.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cap_sensor_scan_scheduler;
  localparam int NS   = 9;
  localparam int CW   = 16;
  localparam int CHG  = 8;
  localparam int TMO  = 1023;
  localparam int THR0 = 200;

  logic clock;
  logic reset;

  cap_sensor_scan_scheduler_if #(.NUM_SENSORS(NS), .CNT_W(CW)) bus ();

  cap_sensor_scan_scheduler #(
    .NUM_SENSORS  (NS),
    .CNT_W        (CW),
    .CHARGE_CYCLES(CHG),
    .TIMEOUT      (TMO),
    .THRESH_RST   (THR0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #50 clock = ~clock;
  end

  initial begin
    #(100 * 30000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  // Reference state.
  int          thr_m;
  logic [NS-1:0] touched_m;
  logic [NS-1:0] prev_m;
  int          committed_m [NS];
  // Cycles each pad stays high after release in the next scan.
  int          dly [NS];

  task automatic model_reset();
    thr_m     = THR0;
    touched_m = '0;
    prev_m    = '0;
    for (int i = 0; i < NS; i++) committed_m[i] = 0;
  endtask

  // One full scan: checks charge length, commit timing and published results.
  // wr_j > 0: threshold write in that measure cycle; wr_j < 0: write in COMMIT.
  task automatic run_scan(input string tag, input int wr_j, input int wr_val, input bit en_after);
    int w, hi, j, x, maxd;
    bit seen;
    logic [NS-1:0] sens;
    logic [NS-1:0] raw;
    int exp_cnt [NS];

    bus.capacitive_sensors_in = '1;
    bus.enable = 1'b1;
    w = 0;
    while (bus.capacitive_sensors_out !== 1'b1 && w < 20) begin
      total++;
      if (bus.busy !== 1'b0) begin
        bad++; $display("FAIL %s busy_before_charge: got %b want 0", tag, bus.busy);
      end
      @(negedge clock);
      w++;
    end
    hi = 0;
    while (bus.capacitive_sensors_out === 1'b1 && hi < 40) begin
      total++;
      if (bus.busy !== 1'b1) begin
        bad++; $display("FAIL %s busy_in_charge: got %b want 1", tag, bus.busy);
      end
      hi++;
      @(negedge clock);
    end
    total++;
    if (hi != CHG) begin
      bad++; $display("FAIL %s charge_len: got %0d want %0d", tag, hi, CHG);
    end

    maxd = 0;
    for (int i = 0; i < NS; i++) if (dly[i] > maxd) maxd = dly[i];
    x = (maxd + 3 < TMO) ? maxd + 3 : TMO;

    j = 1;
    seen = 1'b0;
    while (!seen && j <= TMO + 40) begin
      bus.thresh_we = 1'b0;
      if (bus.scan_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        for (int i = 0; i < NS; i++) sens[i] = (j <= dly[i]);
        bus.capacitive_sensors_in = sens;
        if (j == wr_j) begin
          bus.thresh_we = 1'b1;
          bus.thresh_in = CW'(wr_val);
          thr_m = wr_val;
        end
        if (j == 2) bus.enable = en_after;
        j++;
        @(negedge clock);
      end
    end
    total++;
    if (!seen || j != x + 1) begin
      bad++; $display("FAIL %s commit_cycle: got %0d (seen=%0b) want %0d", tag, j, seen, x + 1);
    end

    for (int i = 0; i < NS; i++) begin
      exp_cnt[i] = (dly[i] + 2 > TMO) ? TMO : dly[i] + 2;
      raw[i] = (exp_cnt[i] >= thr_m);
      committed_m[i] = exp_cnt[i];
    end
`ifdef DEBOUNCE_EN
    for (int i = 0; i < NS; i++) if (raw[i] == prev_m[i]) touched_m[i] = raw[i];
    prev_m = raw;
`else
    touched_m = raw;
`endif
    if (wr_j < 0) begin
      bus.thresh_we = 1'b1;
      bus.thresh_in = CW'(wr_val);
      thr_m = wr_val;
    end
    bus.capacitive_sensors_in = '1;
    @(negedge clock);
    bus.thresh_we = 1'b0;

    total++;
    if (bus.scan_done !== 1'b0) begin
      bad++; $display("FAIL %s scan_done_width: got %b want 0", tag, bus.scan_done);
    end
    total++;
    if (bus.touched !== touched_m) begin
      bad++; $display("FAIL %s touched: got %h want %h", tag, bus.touched, touched_m);
    end
    total++;
    if (bus.busy !== en_after) begin
      bad++; $display("FAIL %s busy_after_commit: got %b want %b", tag, bus.busy, en_after);
    end
    total++;
    if (bus.capacitive_sensors_out !== en_after) begin
      bad++; $display("FAIL %s drive_after_commit: got %b want %b", tag, bus.capacitive_sensors_out, en_after);
    end
    for (int i = 0; i < NS; i++) begin
      bus.rd_sel = 4'(i);
      #1;
      total++;
      if (bus.rd_count !== CW'(committed_m[i])) begin
        bad++; $display("FAIL %s rd_count[%0d]: got %0d want %0d", tag, i, bus.rd_count, committed_m[i]);
      end
    end
    bus.rd_sel = 4'($urandom_range(15, NS));
    #1;
    total++;
    if (bus.rd_count !== '0) begin
      bad++; $display("FAIL %s rd_count_oob sel=%0d: got %0d want 0", tag, bus.rd_sel, bus.rd_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.capacitive_sensors_in = '0;
    bus.thresh_we = 1'b0;
    bus.thresh_in = '0;
    bus.rd_sel = '0;
    model_reset();
    repeat (3) @(negedge clock);
    total++;
    if (bus.capacitive_sensors_out !== 1'b0) begin bad++; $display("FAIL reset_drive: got %b want 0", bus.capacitive_sensors_out); end
    total++;
    if (bus.touched !== '0) begin bad++; $display("FAIL reset_touched: got %h want 0", bus.touched); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++;
    if (bus.scan_done !== 1'b0) begin bad++; $display("FAIL reset_scan_done: got %b want 0", bus.scan_done); end
    for (int i = 0; i < NS; i++) begin
      bus.rd_sel = 4'(i);
      #1;
      total++;
      if (bus.rd_count !== '0) begin bad++; $display("FAIL reset_rd_count[%0d]: got %0d want 0", i, bus.rd_count); end
    end
    bus.enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_idle();
    repeat (3) begin
      @(negedge clock);
      total++;
      if (bus.busy !== 1'b0 || bus.capacitive_sensors_out !== 1'b0) begin
        bad++; $display("FAIL idle_hold: got busy=%b drive=%b want 0/0", bus.busy, bus.capacitive_sensors_out);
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < NS; i++) dly[i] = 5;
    dly[3] = 300;
    run_scan("basic", 0, 0, 1'b0);
  endtask

  task automatic test_thresh_write();
    for (int i = 0; i < NS; i++) dly[i] = 5;
    dly[3] = 300;
    dly[4] = 398;
    dly[6] = 397;
    run_scan("thresh_write", 3, 400, 1'b0);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < NS; i++) dly[i] = 0;
    dly[0] = 2000;
    run_scan("timeout", 0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NS; i++) dly[i] = 0;
    dly[1] = 40;
    run_scan("b2b_first", -1, 100, 1'b1);
    for (int i = 0; i < NS; i++) dly[i] = 0;
    dly[7] = 250;
    run_scan("b2b_second", 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int w;
    bus.capacitive_sensors_in = '1;
    w = 0;
    while (bus.capacitive_sensors_out !== 1'b1 && w < 20) begin @(negedge clock); w++; end
    while (bus.capacitive_sensors_out === 1'b1 && w < 60) begin @(negedge clock); w++; end
    repeat (20) @(negedge clock);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_measure_busy: got %b want 1", bus.busy); end
    reset = 1'b0;
    bus.enable = 1'b0;
    @(negedge clock);
    model_reset();
    total++;
    if (bus.capacitive_sensors_out !== 1'b0) begin bad++; $display("FAIL mid_reset_drive: got %b want 0", bus.capacitive_sensors_out); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
    total++;
    if (bus.touched !== '0) begin bad++; $display("FAIL mid_reset_touched: got %h want 0", bus.touched); end
    total++;
    if (bus.scan_done !== 1'b0) begin bad++; $display("FAIL mid_reset_scan_done: got %b want 0", bus.scan_done); end
    bus.rd_sel = 4'd7;
    #1;
    total++;
    if (bus.rd_count !== '0) begin bad++; $display("FAIL mid_reset_rd_count: got %0d want 0", bus.rd_count); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < NS; i++) dly[i] = 3;
    dly[4] = 198;
    dly[6] = 197;
    run_scan("reset_thresh_boundary", 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int r, wj, wv;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NS; i++) begin
        dly[i] = ($urandom_range(1, 0) == 1) ? int'($urandom_range(30, 0)) : int'($urandom_range(450, 100));
      end
      r  = int'($urandom_range(3, 0));
      wj = (r == 3) ? -1 : r;
      wv = int'($urandom_range(450, 50));
      run_scan($sformatf("random%0d", k), wj, wv, (k != 5));
    end
  endtask

  task automatic test_debounce_pair();
    for (int i = 0; i < NS; i++) dly[i] = 0;
    dly[2] = 320;
    run_scan("pair_first", 1, 250, 1'b1);
    run_scan("pair_second", 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_thresh_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_boundary();
    test_random();
    test_debounce_pair();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
